// File: rtl/fifo_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_arbiter
//  Purpose  : Read-side scheduler in the RCLK domain. Drains two FIFO
//             instances (ch0, ch1) into one registered valid/ready output
//             stream. Grants are round-robin and burst based: up to
//             BURST_LEN words per grant, and a grant whose channel runs
//             empty waits TIMEOUT cycles for a refill before it is released.
//
//  Parameters
//    WIDTH      data word width (must match the FIFO instances)
//    BURST_LEN  maximum words popped per grant, 1..255
//    TIMEOUT    empty-wait cycles before release; 0 = release on empty
//
//  Ports
//    RCLK        read-domain clock, rising edge
//    RST         synchronous active-high reset
//    CH_EN[1:0]  per-channel enable
//    REMPTYi     FIFO i empty flag
//    DATAi       FIFO i DATA_OUT (word at read pointer)
//    RDi         FIFO i read strobe (combinational)
//    OUT_DATA    registered output word
//    OUT_VALID   OUT_DATA holds a word
//    OUT_READY   downstream accepts the word at this edge
//    OUT_CH      source channel of OUT_DATA
//    OUT_LAST    OUT_DATA is the BURST_LEN-th word of its grant
//    GRANT[1:0]  one-hot current grant, 00 when idle
//    BUSY        scheduler is not idle
//
//  Optional build macro : FIFO_RD_ARB_STAT_EN
//    Adds STAT_CNT0/STAT_CNT1 (32-bit saturating per-channel pop counts)
//    and STAT_TO (8-bit saturating count of timeout releases).
//
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic             RCLK,
    input  logic             RST,
    input  logic [1:0]       CH_EN,
    input  logic             REMPTY0,
    input  logic [WIDTH-1:0] DATA0,
    output logic             RD0,
    input  logic             REMPTY1,
    input  logic [WIDTH-1:0] DATA1,
    output logic             RD1,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_CH,
    output logic             OUT_LAST,
    output logic [1:0]       GRANT,
    output logic             BUSY
`ifdef FIFO_RD_ARB_STAT_EN
    ,
    output logic [31:0]      STAT_CNT0,
    output logic [31:0]      STAT_CNT1,
    output logic [7:0]       STAT_TO
`endif
);

    // Timer only has to reach TIMEOUT; keep at least one bit so the
    // declaration stays legal when TIMEOUT is 0 (WAIT is then unreachable).
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [7:0]    c_burst_len = 8'(BURST_LEN);
    localparam logic [TW-1:0] c_timeout   = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [1:0]       grant_q,     grant_d;
    logic             last_q,      last_d;      // last-granted channel
    logic [7:0]       beat_q,      beat_d;
    logic [TW-1:0]    timer_q,     timer_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_ch_q,    out_ch_d;
    logic             out_last_q,  out_last_d;

    logic             w_can_take;
    logic             w_sel;
    logic             w_sel_en;
    logic             w_sel_empty;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_pop;
    logic [7:0]       w_beat_inc;
    logic             w_burst_done;
    logic [1:0]       w_elig;
    logic             w_pick;
    logic [TW-1:0]    w_timer_inc;

    // ------------------------------------------------------------------
    // Datapath selection for the granted channel
    // ------------------------------------------------------------------
    assign w_can_take   = !out_valid_q || OUT_READY;
    assign w_sel        = grant_q[1];
    assign w_sel_en     = CH_EN[w_sel];
    assign w_sel_empty  = w_sel ? REMPTY1 : REMPTY0;
    assign w_sel_data   = w_sel ? DATA1 : DATA0;

    // Pop is suppressed while RST is high so a reset edge never consumes
    // a FIFO word that the output register is about to discard.
    assign w_pop        = !RST && (state_q == ST_BURST) && (grant_q != 2'b00) &&
                          w_sel_en && !w_sel_empty && w_can_take;
    assign RD0          = w_pop && grant_q[0];
    assign RD1          = w_pop && grant_q[1];

    assign w_beat_inc   = beat_q + 8'd1;
    assign w_burst_done = (w_beat_inc == c_burst_len);
    assign w_timer_inc  = timer_q + TW'(1);

    // Arbitration: with both eligible, the channel not granted last wins.
    assign w_elig       = CH_EN & ~{REMPTY1, REMPTY0};
    assign w_pick       = (&w_elig) ? ~last_q : w_elig[1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        beat_d      = beat_q;
        timer_d     = timer_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;

        // Output register: load on pop, otherwise drain on OUT_READY.
        if (w_pop) begin
            out_data_d  = w_sel_data;
            out_valid_d = 1'b1;
            out_ch_d    = w_sel;
            beat_d      = w_beat_inc;
            out_last_d  = w_burst_done;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|w_elig) begin
                    grant_d = w_pick ? 2'b10 : 2'b01;
                    beat_d  = 8'd0;
                    timer_d = '0;
                    state_d = ST_BURST;
                end
            end

            ST_BURST: begin
                if ((w_pop && w_burst_done) || !w_sel_en) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    last_d  = w_sel;
                end else if (w_sel_empty) begin
                    if (TIMEOUT > 0) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        last_d  = w_sel;
                    end
                end
                // Otherwise stalled by backpressure or mid-burst: stay.
            end

            ST_WAIT: begin
                if (!w_sel_en) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    last_d  = w_sel;
                end else if (!w_sel_empty) begin
                    // Refill: resume the same burst, beat count preserved.
                    state_d = ST_BURST;
                    timer_d = '0;
                end else begin
                    timer_d = w_timer_inc;
                    if (w_timer_inc == c_timeout) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        last_d  = w_sel;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge RCLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;     // ch0 wins the first tie
            beat_q      <= 8'd0;
            timer_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            timer_q     <= timer_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_LAST  = out_last_q;
    assign GRANT     = grant_q;
    assign BUSY      = (state_q != ST_IDLE);

`ifdef FIFO_RD_ARB_STAT_EN
    // ------------------------------------------------------------------
    // Statistics counters (saturating)
    // ------------------------------------------------------------------
    logic [31:0] stat_cnt0_q, stat_cnt0_d;
    logic [31:0] stat_cnt1_q, stat_cnt1_d;
    logic [7:0]  stat_to_q,   stat_to_d;
    logic        w_to_fire;

    // Same condition as the WAIT timeout release above.
    assign w_to_fire = (state_q == ST_WAIT) && w_sel_en && w_sel_empty &&
                       (w_timer_inc == c_timeout);

    always_comb begin
        stat_cnt0_d = stat_cnt0_q;
        stat_cnt1_d = stat_cnt1_q;
        stat_to_d   = stat_to_q;
        if (RD0 && (stat_cnt0_q != 32'hFFFF_FFFF)) begin
            stat_cnt0_d = stat_cnt0_q + 32'd1;
        end
        if (RD1 && (stat_cnt1_q != 32'hFFFF_FFFF)) begin
            stat_cnt1_d = stat_cnt1_q + 32'd1;
        end
        if (w_to_fire && (stat_to_q != 8'hFF)) begin
            stat_to_d = stat_to_q + 8'd1;
        end
    end

    always_ff @(posedge RCLK) begin
        if (RST) begin
            stat_cnt0_q <= 32'd0;
            stat_cnt1_q <= 32'd0;
            stat_to_q   <= 8'd0;
        end else begin
            stat_cnt0_q <= stat_cnt0_d;
            stat_cnt1_q <= stat_cnt1_d;
            stat_to_q   <= stat_to_d;
        end
    end

    assign STAT_CNT0 = stat_cnt0_q;
    assign STAT_CNT1 = stat_cnt1_q;
    assign STAT_TO   = stat_to_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_arbiter
//  Purpose  : Self-checking bench for fifo_rd_arbiter. Two queue-backed
//             FIFO models feed the DUT under randomized fill, enable,
//             backpressure and reset traffic; a transaction-level reference
//             model predicts strobes, output word and grant every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

    localparam int WIDTH = 16;
    localparam int BL    = 8;
    localparam int TO    = 4;
    localparam int NCYC  = 4000;

    localparam int M_IDLE  = 0;
    localparam int M_BURST = 1;
    localparam int M_WAIT  = 2;

    logic             rclk = 1'b0;
    logic             rst;
    logic [1:0]       ch_en;
    logic             rempty0, rempty1;
    logic [WIDTH-1:0] data0, data1;
    logic             rd0, rd1;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_ch;
    logic             out_last;
    logic [1:0]       grant;
    logic             busy;
`ifdef FIFO_RD_ARB_STAT_EN
    logic [31:0]      stat_cnt0, stat_cnt1;
    logic [7:0]       stat_to;
`endif

    always #10 rclk = ~rclk;

    fifo_rd_arbiter #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .RCLK      (rclk),
        .RST       (rst),
        .CH_EN     (ch_en),
        .REMPTY0   (rempty0),
        .DATA0     (data0),
        .RD0       (rd0),
        .REMPTY1   (rempty1),
        .DATA1     (data1),
        .RD1       (rd1),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_CH    (out_ch),
        .OUT_LAST  (out_last),
        .GRANT     (grant),
        .BUSY      (busy)
`ifdef FIFO_RD_ARB_STAT_EN
        ,
        .STAT_CNT0 (stat_cnt0),
        .STAT_CNT1 (stat_cnt1),
        .STAT_TO   (stat_to)
`endif
    );

    // FIFO contents: element 0 is the word at the read pointer.
    logic [WIDTH-1:0] fq0[$];
    logic [WIDTH-1:0] fq1[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: grant holder, burst progress and the output slot.
    int               m_mode;
    int               m_ch;
    int               m_last;
    int               m_beats;
    int               m_wait;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_och;
    logic             m_olast;
    int unsigned      m_cnt0, m_cnt1, m_to;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_ch    = 0;
        m_last  = 1;
        m_beats = 0;
        m_wait  = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_och   = 1'b0;
        m_olast = 1'b0;
        m_cnt0  = 0;
        m_cnt1  = 0;
        m_to    = 0;
    endtask

    task automatic model_release();
        m_mode = M_IDLE;
        m_last = m_ch;
    endtask

    initial begin : main
        int         phase;
        int         pp;
        logic [1:0] emp;
        logic [1:0] m_rd;
        logic [1:0] exp_grant;
        logic       take;
        logic       popped;

        rst       = 1'b1;
        ch_en     = 2'b11;
        out_ready = 1'b1;
        rempty0   = 1'b1;
        rempty1   = 1'b1;
        data0     = '0;
        data1     = '0;
        model_reset();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge rclk);

            // ---------------- stimulus ----------------
            phase = (cyc / 500) % 4;
            rst   = (cyc < 3) || ($urandom_range(0, 299) == 0);
            case (phase)
                0: pp = 80;   // both channels full: arbitration/burst length
                1: pp = 6;    // sparse: timeouts and refill during wait
                2: pp = 40;
                default: pp = 25;
            endcase
            if (fq0.size() < 32 && $urandom_range(0, 99) < pp) fq0.push_back(WIDTH'($urandom));
            if (fq1.size() < 32 && $urandom_range(0, 99) < pp) fq1.push_back(WIDTH'($urandom));

            case (phase)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 9) != 0);
                2: if ($urandom_range(0, 11) == 0) out_ready = ~out_ready;  // long stalls
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase

            if (phase < 2) ch_en = 2'b11;
            else if ($urandom_range(0, 39) == 0) ch_en = 2'($urandom_range(0, 3));

            rempty0 = (fq0.size() == 0);
            rempty1 = (fq1.size() == 0);
            data0   = rempty0 ? WIDTH'($urandom) : fq0[0];
            data1   = rempty1 ? WIDTH'($urandom) : fq1[0];
            emp     = {rempty1, rempty0};

            #1;
            // ---------------- expected strobes ----------------
            take = !m_valid || out_ready;
            for (int i = 0; i < 2; i++) begin
                m_rd[i] = !rst && (m_mode == M_BURST) && (m_ch == i) &&
                          ch_en[i] && !emp[i] && take;
            end
            exp_grant = (m_mode == M_IDLE) ? 2'b00 : ((m_ch == 1) ? 2'b10 : 2'b01);

            if (cyc > 0) begin
                check_eq("rd0",       {31'd0, rd0},       {31'd0, m_rd[0]});
                check_eq("rd1",       {31'd0, rd1},       {31'd0, m_rd[1]});
                check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
                check_eq("out_data",  {16'd0, out_data},  {16'd0, m_data});
                check_eq("out_ch",    {31'd0, out_ch},    {31'd0, m_och});
                check_eq("out_last",  {31'd0, out_last},  {31'd0, m_olast});
                check_eq("grant",     {30'd0, grant},     {30'd0, exp_grant});
                check_eq("busy",      {31'd0, busy},      {31'd0, (m_mode != M_IDLE)});
`ifdef FIFO_RD_ARB_STAT_EN
                check_eq("stat_cnt0", stat_cnt0, m_cnt0);
                check_eq("stat_cnt1", stat_cnt1, m_cnt1);
                check_eq("stat_to",   {24'd0, stat_to}, m_to);
`endif
            end

            @(posedge rclk);
            // ---------------- model update at the edge ----------------
            if (rst) begin
                model_reset();
            end else begin
                popped = m_rd[0] || m_rd[1];
                if (popped) begin
                    if (m_ch == 0) begin
                        m_data = fq0.pop_front();
                        m_cnt0++;
                    end else begin
                        m_data = fq1.pop_front();
                        m_cnt1++;
                    end
                    m_valid = 1'b1;
                    m_och   = (m_ch == 1);
                    m_beats++;
                    m_olast = (m_beats == BL);
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end

                case (m_mode)
                    M_IDLE: begin
                        if ((ch_en[0] && !emp[0]) || (ch_en[1] && !emp[1])) begin
                            if (ch_en[0] && !emp[0] && ch_en[1] && !emp[1])
                                m_ch = 1 - m_last;
                            else
                                m_ch = (ch_en[0] && !emp[0]) ? 0 : 1;
                            m_mode  = M_BURST;
                            m_beats = 0;
                            m_wait  = 0;
                        end
                    end
                    M_BURST: begin
                        if (popped && m_beats == BL)   model_release();
                        else if (!ch_en[m_ch])         model_release();
                        else if (emp[m_ch]) begin
                            if (TO > 0) begin
                                m_mode = M_WAIT;
                                m_wait = 0;
                            end else begin
                                model_release();
                            end
                        end
                    end
                    default: begin
                        if (!ch_en[m_ch]) begin
                            model_release();
                        end else if (!emp[m_ch]) begin
                            m_mode = M_BURST;
                            m_wait = 0;
                        end else begin
                            m_wait++;
                            if (m_wait == TO) begin
                                model_release();
                                if (m_to < 255) m_to++;
                            end
                        end
                    end
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
